// File: rtl/drum_cmd_scheduler.sv
// drum_cmd_scheduler
// Collects one-cycle drum trigger pulses from NUM_SRC independent sources,
// arbitrates them round-robin into a command FIFO and feeds the single drum
// SPI slave one command at a time.
//
// Handshake: drum_trigger_valid is a one-cycle issue pulse. drum_code is valid
// from that pulse until the next issue. The slave answers with a one-cycle
// command_sent pulse. The next command is issued only after that acknowledge
// (or an acknowledge timeout) plus GAP_CYCLES idle cycles. command_sent seen
// outside the wait-for-acknowledge window is ignored.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   src_valid[i]        trigger pulse from source i
//   src_code[4i+3:4i]   drum code of source i (bit 3 set = illegal)
//   drum_trigger_valid  command issue pulse
//   drum_code           issued command code
//   command_sent        acknowledge pulse from the SPI slave
//   busy                FSM not idle or FIFO non-empty
//   fifo_count          FIFO occupancy
//   drop_count          saturating count of lost/rejected triggers
//   timeout_count       saturating count of acknowledge timeouts
//
// Optional build macro: DRUM_CMD_COALESCE_EN -- a granted code equal to the
// newest still-unissued FIFO entry is absorbed instead of pushed.
module drum_cmd_scheduler #(
  parameter int NUM_SRC     = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 65536,
  parameter int GAP_CYCLES  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [4*NUM_SRC-1:0]          src_code,
  output logic                          drum_trigger_valid,
  output logic [3:0]                    drum_code,
  input  logic                          command_sent,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_count,
  output logic [7:0]                    timeout_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int SW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int TMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_GAP} state_t;

  state_t            state, state_next;
  logic [TW-1:0]     timer, timer_next;
  logic              timeout_hit;
  logic              load_code;

  logic [NUM_SRC-1:0] pending;
  logic [3:0]         hold_code [NUM_SRC];
  logic [SW-1:0]      last_grant;
  logic               grant_vld;
  logic [SW-1:0]      grant_idx;
  logic [3:0]         drops;
  logic [8:0]         drop_sum;

  logic [3:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic               push, pop, coalesce;

  // Round-robin: walk from the farthest candidate to the nearest so the
  // source closest after last_grant is the final (winning) assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (fifo_count != FULL) begin
      for (int k = NUM_SRC; k >= 1; k--) begin
        if (pending[(int'(last_grant) + k) % NUM_SRC]) begin
          grant_vld = 1'b1;
          grant_idx = SW'((int'(last_grant) + k) % NUM_SRC);
        end
      end
    end
  end

  // A pulse on a source that is being granted this cycle is a fresh request,
  // not an overwrite, so it is not a drop.
  always_comb begin
    drops = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i]) begin
        if (src_code[4*i+3]) begin
          drops = drops + 4'd1;
        end else if (pending[i] && !(grant_vld && grant_idx == SW'(i))) begin
          drops = drops + 4'd1;
        end
      end
    end
    drop_sum = {1'b0, drop_count} + {5'b0, drops};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      last_grant <= '0;
      drop_count <= '0;
      for (int i = 0; i < NUM_SRC; i++) hold_code[i] <= '0;
    end else begin
      if (grant_vld) begin
        pending[grant_idx] <= 1'b0;
        last_grant         <= grant_idx;
      end
      // Later assignment wins: a new legal pulse re-arms pending even if the
      // source was just granted.
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && !src_code[4*i+3]) begin
          pending[i]   <= 1'b1;
          hold_code[i] <= src_code[4*i +: 4];
        end
      end
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

`ifdef DRUM_CMD_COALESCE_EN
  logic [AW-1:0] tail_ptr;
  logic          tail_live;
  assign tail_ptr  = wr_ptr - 1'b1;
  // The newest entry is unissued unless it is the only one and leaves now.
  assign tail_live = (fifo_count != '0) && !(pop && fifo_count == (AW+1)'(1));
  assign coalesce  = tail_live && (mem[tail_ptr] == hold_code[grant_idx]);
`else
  assign coalesce  = 1'b0;
`endif

  assign push = grant_vld && !coalesce;
  assign pop  = (state == S_ISSUE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= hold_code[grant_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // The timer is shared: acknowledge wait in WAIT_ACK, idle spacing in GAP.
  always_comb begin
    state_next  = state;
    timer_next  = timer;
    timeout_hit = 1'b0;
    load_code   = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_count != '0) begin
          state_next = S_ISSUE;
          load_code  = 1'b1;
        end
      end
      S_ISSUE: begin
        state_next = S_WAIT_ACK;
        timer_next = '0;
      end
      S_WAIT_ACK: begin
        if (command_sent) begin
          state_next = S_GAP;
          timer_next = '0;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = S_GAP;
          timer_next  = '0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      S_GAP: begin
        if (timer == TW'(GAP_CYCLES - 1)) state_next = S_IDLE;
        else                              timer_next = timer + 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      timer         <= '0;
      drum_code     <= '0;
      timeout_count <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      // Head is loaded on entry to ISSUE so the code is stable for the pulse.
      if (load_code) drum_code <= mem[rd_ptr];
      if (timeout_hit && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
    end
  end

  assign drum_trigger_valid = (state == S_ISSUE);
  assign busy               = (state != S_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_drum_cmd_scheduler.sv
// Self-checking bench for drum_cmd_scheduler. All stepping goes through
// tick(), which also models the SPI slave acknowledge and checks every issued
// command against the expected queue.
module tb_drum_cmd_scheduler;
  localparam int NUM_SRC     = 4;
  localparam int FIFO_DEPTH  = 8;
  localparam int ACK_TIMEOUT = 64;
  localparam int GAP_CYCLES  = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_SRC-1:0]   src_valid = '0;
  logic [4*NUM_SRC-1:0] src_code = '0;
  logic                 drum_trigger_valid;
  logic [3:0]           drum_code;
  logic                 command_sent;
  logic                 busy;
  logic [3:0]           fifo_count;
  logic [7:0]           drop_count;
  logic [7:0]           timeout_count;

  logic auto_ack = 1'b0;
  logic man_ack = 1'b0;
  logic ack_en = 1'b0;
  int   ack_lat = 10;
  int   ack_cnt = 0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_issue = 0;
  int   t_iss = 0;
  int   t_prev = 0;
  logic [3:0] exp_q[$];

  assign command_sent = auto_ack | man_ack;

  always #5 clk = ~clk;

  drum_cmd_scheduler #(
    .NUM_SRC(NUM_SRC), .FIFO_DEPTH(FIFO_DEPTH),
    .ACK_TIMEOUT(ACK_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_code(src_code),
    .drum_trigger_valid(drum_trigger_valid), .drum_code(drum_code),
    .command_sent(command_sent), .busy(busy), .fifo_count(fifo_count),
    .drop_count(drop_count), .timeout_count(timeout_count)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    logic [3:0] e;
    @(negedge clk);
    cyc++;
    auto_ack = 1'b0;
    if (!rst_n) ack_cnt = 0;
    else if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) auto_ack = 1'b1;
    end
    if (drum_trigger_valid) begin
      if (ack_en) ack_cnt = ack_lat;
      n_issue++;
      t_prev = t_iss;
      t_iss  = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: got code %0d, required no issue", drum_code);
      end else begin
        e = exp_q.pop_front();
        if (drum_code !== e) begin
          bad++;
          $display("FAIL issue_code: got %0d, required %0d", drum_code, e);
        end
      end
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_issue(input string name, input int budget);
    int start;
    int n;
    start = n_issue;
    n = 0;
    while (n_issue == start && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (n_issue == start) begin
      bad++;
      $display("FAIL %s: no issue within %0d cycles", name, budget);
    end
  endtask

  task automatic pulse(input int src, input logic [3:0] code);
    src_valid[src]       = 1'b1;
    src_code[4*src +: 4] = code;
    tick();
    src_valid = '0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    src_valid = '0;
    man_ack   = 1'b0;
    ack_en    = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (drum_trigger_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b, required 0", drum_trigger_valid); end
    total++; if (drum_code !== 4'd0) begin bad++; $display("FAIL rst_code: got %0d, required 0", drum_code); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b, required 0", busy); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL rst_fifo: got %0d, required 0", fifo_count); end
    total++; if ({drop_count, timeout_count} !== 16'd0) begin bad++; $display("FAIL rst_counters: got %0d/%0d, required 0/0", drop_count, timeout_count); end
  endtask

  task automatic test_single();
    int t0;
    do_reset();
    ack_en = 1'b1; ack_lat = 10;
    exp_q.push_back(4'd5);
    t0 = cyc;
    pulse(2, 4'd5);
    wait_issue("single_issue", 10);
    total++; if (t_iss - t0 !== 3) begin bad++; $display("FAIL single_latency: got %0d, required 3", t_iss - t0); end
    wait_until(t_iss + 26);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_gap: got %0b, required 1", busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_after: got %0b, required 0", busy); end
  endtask

  task automatic test_round_robin();
    do_reset();
    ack_en = 1'b1; ack_lat = 10;
    exp_q.push_back(4'd2); exp_q.push_back(4'd3);
    exp_q.push_back(4'd4); exp_q.push_back(4'd1);
    src_code  = {4'd4, 4'd3, 4'd2, 4'd1};
    src_valid = 4'hF;
    tick();
    src_valid = '0;
    wait_issue("rr_issue0", 10);
    for (int j = 1; j < 4; j++) begin
      wait_issue("rr_issue", 100);
      total++;
      if (t_iss - t_prev !== ack_lat + GAP_CYCLES + 2) begin
        bad++; $display("FAIL rr_spacing: got %0d, required %0d", t_iss - t_prev, ack_lat + GAP_CYCLES + 2);
      end
    end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL rr_drops: got %0d, required 0", drop_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    ack_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(4'(i % 8));
      pulse(0, 4'(i % 8));
    end
    tick(); tick();
    total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL bp_full: got %0d, required 8", fifo_count); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL bp_no_drop: got %0d, required 0", drop_count); end
    pulse(1, 4'd3);
    pulse(1, 4'd6);
    exp_q.push_back(4'd6);
    tick();
    total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL ow_drop: got %0d, required 1", drop_count); end
    total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL ow_full: got %0d, required 8", fifo_count); end
    pulse(0, 4'd9);
    tick();
    total++; if (drop_count !== 8'd2) begin bad++; $display("FAIL illegal_drop: got %0d, required 2", drop_count); end
    ack_en = 1'b1; ack_lat = 3;
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    for (int j = 0; j < 9; j++) wait_issue("bp_drain", 200);
    repeat (40) tick();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL bp_drained: got %0d left, required 0", exp_q.size()); end
    total++; if (timeout_count !== 8'd0) begin bad++; $display("FAIL bp_timeouts: got %0d, required 0", timeout_count); end
    total++; if (drop_count !== 8'd2) begin bad++; $display("FAIL bp_drop_final: got %0d, required 2", drop_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ack_en = 1'b1; ack_lat = 2;
    exp_q.push_back(4'd7);
`ifndef DRUM_CMD_COALESCE_EN
    exp_q.push_back(4'd7);
`endif
    pulse(3, 4'd7);
    pulse(3, 4'd7);
    wait_issue("b2b_issue", 20);
    repeat (60) tick();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_drained: got %0d left, required 0", exp_q.size()); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL b2b_drops: got %0d, required 0", drop_count); end
  endtask

  task automatic test_timeout();
    int t1;
    int t2;
    do_reset();
    ack_en = 1'b0;
    exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    pulse(0, 4'd1);
    pulse(0, 4'd2);
    wait_issue("to_first", 10);
    t1 = t_iss;
    wait_until(t1 + ACK_TIMEOUT);
    total++; if (timeout_count !== 8'd0) begin bad++; $display("FAIL to_before: got %0d, required 0", timeout_count); end
    tick();
    total++; if (timeout_count !== 8'd1) begin bad++; $display("FAIL to_after: got %0d, required 1", timeout_count); end
    wait_issue("to_next", 100);
    total++; if (t_iss - t1 !== ACK_TIMEOUT + GAP_CYCLES + 2) begin bad++; $display("FAIL to_spacing: got %0d, required %0d", t_iss - t1, ACK_TIMEOUT + GAP_CYCLES + 2); end
    t2 = t_iss;
    wait_until(t2 + ACK_TIMEOUT);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    total++; if (timeout_count !== 8'd1) begin bad++; $display("FAIL ack_and_timeout: got %0d, required 1", timeout_count); end
    wait_until(t2 + ACK_TIMEOUT + GAP_CYCLES);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ack_gap_busy: got %0b, required 1", busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ack_gap_idle: got %0b, required 0", busy); end
  endtask

  task automatic test_reset_mid();
    int n0;
    do_reset();
    ack_en = 1'b0;
    exp_q.push_back(4'd1);
    pulse(0, 4'd1); pulse(0, 4'd2); pulse(0, 4'd3); pulse(0, 4'd4);
    repeat (3) tick();
    total++; if (fifo_count !== 4'd3) begin bad++; $display("FAIL mid_fifo: got %0d, required 3", fifo_count); end
    total++; if (drum_code !== 4'd1) begin bad++; $display("FAIL mid_code: got %0d, required 1", drum_code); end
    rst_n = 1'b0;
    #1;
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL mid_rst_fifo: got %0d, required 0", fifo_count); end
    total++; if ({drum_trigger_valid, drum_code, busy} !== 6'd0) begin bad++; $display("FAIL mid_rst_outputs: got %0h, required 0", {drum_trigger_valid, drum_code, busy}); end
    tick(); tick();
    exp_q.delete();
    rst_n = 1'b1;
    n0 = n_issue;
    repeat (40) tick();
    total++; if (n_issue !== n0) begin bad++; $display("FAIL mid_no_issue: got %0d issues, required 0", n_issue - n0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %0b, required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
